// File: rtl/hazard_controller_pkg.sv
// Shared hazard-control definitions: FSM encoding, zero-register id and mul/div counter width.
// Imported by the hazard controller, the forwarding unit and the decoder.
package hazard_controller_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam int ZERO_REG     = 0;
  localparam int MULDIV_CNT_W = 6;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-controller bundle: decode/exec/mem status in, stage controls out.
// The controller sits on the slave side; the pipeline, or the bench, drives the master side.
interface hazard_controller_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PERF_WIDTH     = 16
) ();

  logic [REG_ADDR_WIDTH-1:0] dec_rs_addr;
  logic [REG_ADDR_WIDTH-1:0] dec_rt_addr;
  logic                      dec_uses_rs;
  logic                      dec_uses_rt;
  logic                      dec_muldiv;
  logic                      dec_uses_hilo;
  logic                      exec_wb;
  logic                      exec_mem_read;
  logic [REG_ADDR_WIDTH-1:0] exec_rd_addr;
  logic                      exec_branch_taken;
  logic                      mem_req;
  logic                      dcache_ready;

  logic                      stall_fetch;
  logic                      stall_dec;
  logic                      bubble_exec;
  logic                      freeze;
  logic                      flush_dec;
  logic                      muldiv_busy;
  logic [PERF_WIDTH-1:0]     miss_cycles;

  modport master (
    output dec_rs_addr, dec_rt_addr, dec_uses_rs, dec_uses_rt, dec_muldiv,
           dec_uses_hilo, exec_wb, exec_mem_read, exec_rd_addr,
           exec_branch_taken, mem_req, dcache_ready,
    input  stall_fetch, stall_dec, bubble_exec, freeze, flush_dec,
           muldiv_busy, miss_cycles
  );

  modport slave (
    input  dec_rs_addr, dec_rt_addr, dec_uses_rs, dec_uses_rt, dec_muldiv,
           dec_uses_hilo, exec_wb, exec_mem_read, exec_rd_addr,
           exec_branch_taken, mem_req, dcache_ready,
    output stall_fetch, stall_dec, bubble_exec, freeze, flush_dec,
           muldiv_busy, miss_cycles
  );

endinterface

// File: rtl/hazard_controller_muldiv_tracker.sv
// Mul/div busy tracker: loads the unit latency on an accepted op, then counts down every cycle.
// Busy is registered, so it is valid from the cycle after acceptance. It never stops counting, even while the pipeline is frozen.
module muldiv_tracker
  import hazard_controller_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = MULDIV_CNT_W'(MULDIV_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_controller.sv
// Hazard sequencer for stall, freeze and flush controls: load-use, D-cache miss, mul/div busy and taken branch.
// All controls are combinational in the same cycle. A miss freezes the whole pipe and outranks a branch, which outranks a stall.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MULDIV_CYCLES  = 32,
  parameter int PERF_WIDTH     = 16
) (
  input  logic           clk,
  input  logic           rst,
  hazard_controller_if.slave hif
);

  hz_state_e             state_q, state_d;
  logic [PERF_WIDTH-1:0] miss_cycles_q, miss_cycles_d;

  logic miss_now;
  logic load_use;
  logic hilo_hazard;
  logic muldiv_busy;
  logic muldiv_accept;
  logic stall_fetch, stall_dec, bubble_exec, freeze, flush_dec;

  muldiv_tracker #(
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) u_muldiv_tracker (
    .clk  (clk),
    .rst  (rst),
    .load (muldiv_accept),
    .busy (muldiv_busy)
  );

  assign miss_now = ((state_q == MEM_WAIT) || hif.mem_req) && !hif.dcache_ready;

  assign load_use = hif.exec_mem_read && hif.exec_wb &&
                    (hif.exec_rd_addr != REG_ADDR_WIDTH'(ZERO_REG)) &&
                    ((hif.dec_uses_rs && (hif.dec_rs_addr == hif.exec_rd_addr)) ||
                     (hif.dec_uses_rt && (hif.dec_rt_addr == hif.exec_rd_addr)));

  assign hilo_hazard = muldiv_busy && (hif.dec_uses_hilo || hif.dec_muldiv);

  // Priority: miss freezes everything, then a taken branch kills decode, then data stalls.
  always_comb begin
    stall_fetch = 1'b0;
    stall_dec   = 1'b0;
    bubble_exec = 1'b0;
    freeze      = 1'b0;
    flush_dec   = 1'b0;
    if (miss_now) begin
      freeze      = 1'b1;
      stall_fetch = 1'b1;
      stall_dec   = 1'b1;
    end else if (hif.exec_branch_taken) begin
      flush_dec   = 1'b1;
    end else if (load_use || hilo_hazard) begin
      stall_fetch = 1'b1;
      stall_dec   = 1'b1;
      bubble_exec = 1'b1;
    end
  end

  assign muldiv_accept = hif.dec_muldiv && !stall_dec && !flush_dec;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (hif.mem_req && !hif.dcache_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (hif.dcache_ready)                 state_d = RUN;
      default:                                        state_d = RUN;
    endcase
  end

  always_comb begin
    miss_cycles_d = miss_cycles_q;
    if ((state_q == MEM_WAIT) && (miss_cycles_q != {PERF_WIDTH{1'b1}})) begin
      miss_cycles_d = miss_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      miss_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      miss_cycles_q <= miss_cycles_d;
    end
  end

  assign hif.stall_fetch = stall_fetch;
  assign hif.stall_dec   = stall_dec;
  assign hif.bubble_exec = bubble_exec;
  assign hif.freeze      = freeze;
  assign hif.flush_dec   = flush_dec;
  assign hif.muldiv_busy = muldiv_busy;
  assign hif.miss_cycles = miss_cycles_q;

endmodule
